uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the receive-side counterpart of the team's 8N1 UART transmitter.
- Recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from the asynchronous RxD pin.
- Uses the same system clock and clock-counted baud timing as the transmitter.
- Presents each received byte with a one-cycle valid strobe to downstream logic (LED display / loopback into the transmitter).

Parameters:
CLKS_PER_BIT, 10416, system clocks per bit period (100 MHz / 9600 baud); legal range 4..65535.
HALF_BIT, CLKS_PER_BIT/2 (integer divide), clocks from start-edge detection to start-bit mid-sample.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted); released synchronously by the system.
RxD  input  1  serial line; idle high; asynchronous to clk.
rx_data  output  8  last successfully received byte; held stable until the next good frame.
rx_valid  output  1  one-cycle pulse: rx_data updated this cycle.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; baud counter=0; bit counter=0; shift register=0.
  - Synchronizer flops set to 1 (line idle).
  - Outputs: rx_data=0x00, rx_valid=0, frame_err=0, busy=0.
  - Reset mid-frame aborts the frame with no valid or error pulse.
- Input sync: RxD passes through a 2-flop synchronizer. All decisions below use the synchronized value rx_s. Pin-to-rx_s delay is 2 clocks.
- Baud counter: 16-bit, counts up by 1 per clock in START/DATA/STOP. Cleared to 0 on every state transition and every bit sample.
- Counter widths: baud counter 16 bits; bit counter 3 bits, wraps 7 -> 0 on the 8th data bit.
- IDLE: busy=0. If rx_s==0, go to START with counter=0.
- START:
  - At counter==HALF_BIT-1: if rx_s==0, go to DATA (counter=0, bitcnt=0).
  - If rx_s==1 at that point, treat as a glitch: return to IDLE silently, no pulse.
- DATA:
  - At counter==CLKS_PER_BIT-1, shift rx_s in as the MSB (shreg <= {rx_s, shreg[7:1]}), which yields LSB-first order, and increment bitcnt.
  - After the 8th sample (bitcnt wraps 7 -> 0), go to STOP.
- STOP, at counter==CLKS_PER_BIT-1:
  - rx_s==1: rx_data<=shreg; rx_valid=1 for exactly one clock; go to IDLE.
  - rx_s==0: frame_err=1 for one clock; rx_data unchanged; go to BREAK.
- BREAK: stay until rx_s==1, then go to IDLE. A held-low line (break condition) produces only one frame_err.
- Sample timing: all samples fall at bit centres (± 1 clock) relative to the synchronized falling edge.
- Latency: rx_valid asserts 2 + HALF_BIT + 9*CLKS_PER_BIT clocks after the start-bit falling edge at the pin (± 1 clock).
- Back-to-back frames:
  - IDLE is re-entered half a bit before the stop-bit end, so a start bit immediately following a stop bit is caught with no lost frame.
  - The next byte overwrites rx_data; there is no overrun detection.
- rx_valid and frame_err are never high in the same cycle. Both are registered outputs.

Test Plan:
1. CLKS_PER_BIT=16; drive frame 0x55 (start 0, bits 1,0,1,0,1,0,1,0 LSB first, stop 1) -> one rx_valid pulse, rx_data=0x55, frame_err never high, busy low afterwards.
2. Two back-to-back frames 0xA3 then 0x0F with no idle gap -> two rx_valid pulses exactly 10*16 clocks apart; rx_data=0xA3 then 0x0F.
3. 4-clock low glitch on RxD while idle -> returns to IDLE after the half-bit check; no rx_valid, no frame_err, rx_data unchanged.
4. Frame 0xC6 with stop bit driven 0, then line held low 50 clocks, then high -> single frame_err pulse, no rx_valid, rx_data keeps the previous value; next good frame 0x12 is received correctly.
5. reset pulsed low during data bit 4 of a frame -> outputs immediately at reset values, busy=0; the remainder of the aborted frame yields no valid pulse and no error pulse; a subsequent frame 0x81 is received correctly.
6. CLKS_PER_BIT=10416; single frame 0x3C -> rx_valid at 2+5208+93744 clocks (±1) after the start edge, rx_data=0x3C.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling from a clock-counted
// baud counter, one-cycle rx_valid / frame_err strobes on registered outputs.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_baud;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shreg;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;

  logic        w_rx_s;
  logic        w_half_done;
  logic        w_bit_done;
  logic        w_busy;
  logic        w_counting;
  logic        w_sample;
  logic        w_good;
  logic        w_bad;

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RxD;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s      = r_sync2;
  assign w_half_done = (r_baud == HALF_LAST);
  assign w_bit_done  = (r_baud == BIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_rx_s) w_next = S_START;
      S_START: if (w_half_done) w_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_bit_done && (r_bitcnt == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_bit_done) w_next = w_rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (w_rx_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_counting = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
    w_sample   = (r_state == S_DATA) && w_bit_done;
    w_good     = (r_state == S_STOP) && w_bit_done && w_rx_s;
    w_bad      = (r_state == S_STOP) && w_bit_done && !w_rx_s;
  end

  // Stop-bit decision lands half a bit early, leaving IDLE ready for a back-to-back start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      if ((r_state != w_next) || w_sample) begin
        r_baud <= '0;
      end else if (w_counting) begin
        r_baud <= r_baud + 16'd1;
      end
      if ((r_state == S_START) && (w_next == S_DATA)) begin
        r_bitcnt <= '0;
      end else if (w_sample) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_sample) begin
        r_shreg <= {w_rx_s, r_shreg[7:1]};
      end
      if (w_good) begin
        r_data <= r_shreg;
      end
      r_valid <= w_good;
      r_ferr  <= w_bad;
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign busy      = w_busy;

endmodule
